// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode constants, NOP encoding and interlock FSM states
package rv_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic {RUN, STALL} state_t;
endpackage

// File: rtl/rv_src_use.sv
// rv_src_use: decodes which source register fields an opcode actually reads
//   opcode   in  instruction bits [6:0]
//   uses_rs1 out rs1 field [19:15] is a real operand
//   uses_rs2 out rs2 field [24:20] is a real operand
module rv_src_use
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);
    assign uses_rs1 = opcode inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    assign uses_rs2 = opcode inside {OP_OP, OP_STORE, OP_BRANCH};
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use interlock and taken-branch flush for a 5-stage RV32I pipeline
//   clk, rst                  clock, asynchronous active-high reset
//   IF_ID_IR, ID_EX_IR        instructions currently in ID and EX
//   branch_taken              EX redirected the PC this cycle
//   pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush   pipeline controls
//   stall_cnt, flush_cnt      saturating event counters
module hazard_stall_ctrl
    import rv_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IF_ID_IR,
    input  logic [31:0]      ID_EX_IR,
    input  logic             branch_taken,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    state_t     state, state_n;
    logic [2:0] rem, rem_n;
    logic       use1, use2, load_hazard, stall, flush;
    logic [4:0] rd;
    logic       unused_bits;

    rv_src_use u_src (
        .opcode   (IF_ID_IR[6:0]),
        .uses_rs1 (use1),
        .uses_rs2 (use2)
    );

    assign unused_bits = ^{IF_ID_IR[31:25], IF_ID_IR[14:7], ID_EX_IR[31:12]};
    assign rd = ID_EX_IR[11:7];
    assign load_hazard = ID_EX_IR[6:0] == OP_LOAD && rd != 5'd0 &&
                         ((use1 && rd == IF_ID_IR[19:15]) || (use2 && rd == IF_ID_IR[24:20]));

    // Outputs are gated by rst so the pipeline runs freely while reset is held.
    always_comb begin
        flush          = !rst && branch_taken;
        stall          = !rst && !branch_taken && (state == STALL || load_hazard);
        pc_write_en    = !stall;
        if_id_write_en = !stall;
        id_ex_bubble   = stall || flush;
        if_id_flush    = flush;
        state_n        = state;
        rem_n          = rem;
        if (branch_taken) begin
            state_n = RUN;
            rem_n   = 3'd0;
        end else if (state == STALL) begin
            state_n = rem == 3'd1 ? RUN : STALL;
            rem_n   = rem - 3'd1;
        end else if (load_hazard && LOAD_LAT > 1) begin
            state_n = STALL;
            rem_n   = 3'(LOAD_LAT - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            rem       <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_taken && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed table and sequence checks on three latency/width variants
module tb_hazard_stall_ctrl;
    import rv_pkg::*;

    localparam logic [31:0] LW5  = 32'h0000_A283;
    localparam logic [31:0] ADD5 = 32'h0022_8333;

    typedef struct {
        logic [31:0] id_ex;
        logic [31:0] if_id;
        logic        br;
        logic [3:0]  exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_ex, if_id;
    logic        br;

    logic pc1, ifw1, bub1, fl1, pc3, ifw3, bub3, fl3, pc4, ifw4, bub4, fl4;
    logic [31:0] sc1, fc1, sc3, fc3;
    logic [3:0]  sc4, fc4;
    logic [3:0]  o1, o3, o4;

    int n_chk = 0;
    int n_fail = 0;
    vec_t tv[14];

    assign o1 = {pc1, ifw1, bub1, fl1};
    assign o3 = {pc3, ifw3, bub3, fl3};
    assign o4 = {pc4, ifw4, bub4, fl4};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .IF_ID_IR(if_id), .ID_EX_IR(id_ex), .branch_taken(br),
        .pc_write_en(pc1), .if_id_write_en(ifw1), .id_ex_bubble(bub1), .if_id_flush(fl1),
        .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(32)) u3 (
        .clk(clk), .rst(rst), .IF_ID_IR(if_id), .ID_EX_IR(id_ex), .branch_taken(br),
        .pc_write_en(pc3), .if_id_write_en(ifw3), .id_ex_bubble(bub3), .if_id_flush(fl3),
        .stall_cnt(sc3), .flush_cnt(fc3));

    hazard_stall_ctrl #(.LOAD_LAT(4), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .IF_ID_IR(if_id), .ID_EX_IR(id_ex), .branch_taken(br),
        .pc_write_en(pc4), .if_id_write_en(ifw4), .id_ex_bubble(bub4), .if_id_flush(fl4),
        .stall_cnt(sc4), .flush_cnt(fc4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] e, input logic [31:0] d, input logic b);
        id_ex = e;
        if_id = d;
        br    = b;
    endtask

    task automatic do_reset();
        set_in(NOP_INSTR, NOP_INSTR, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = '{LW5,               ADD5,          1'b0, 4'b0010, "add_rs1_hazard"};
        tv[1]  = '{LW5,               32'h0051_2023, 1'b0, 4'b0010, "sw_rs2_hazard"};
        tv[2]  = '{LW5,               32'h0002_8337, 1'b0, 4'b1100, "lui_no_src"};
        tv[3]  = '{32'h0000_A003,     32'h0000_0333, 1'b0, 4'b1100, "lw_x0"};
        tv[4]  = '{LW5,               32'h0012_8313, 1'b0, 4'b0010, "addi_rs1_hazard"};
        tv[5]  = '{LW5,               32'h0050_8313, 1'b0, 4'b1100, "addi_imm_not_rs2"};
        tv[6]  = '{LW5,               32'h0050_0063, 1'b0, 4'b0010, "beq_rs2_hazard"};
        tv[7]  = '{LW5,               32'h0002_80E7, 1'b0, 4'b0010, "jalr_rs1_hazard"};
        tv[8]  = '{LW5,               32'h0052_806F, 1'b0, 4'b1100, "jal_no_src"};
        tv[9]  = '{LW5,               32'h0002_8317, 1'b0, 4'b1100, "auipc_no_src"};
        tv[10] = '{ADD5,              ADD5,          1'b0, 4'b1100, "ex_not_load"};
        tv[11] = '{LW5,               ADD5,          1'b1, 4'b1111, "flush_beats_hazard"};
        tv[12] = '{NOP_INSTR,         NOP_INSTR,     1'b1, 4'b1111, "flush_plain"};
        tv[13] = '{NOP_INSTR,         NOP_INSTR,     1'b0, 4'b1100, "idle"};

        // reset holds outputs enabled even with hazardous IRs present
        rst = 1'b1;
        set_in(LW5, ADD5, 1'b0);
        #12;
        chk("reset_out_u1", 32'(o1), 32'(4'b1100));
        chk("reset_out_u4", 32'(o4), 32'(4'b1100));
        chk("reset_stall_cnt", sc1, 0);
        chk("reset_flush_cnt", fc1, 0);
        tick();
        rst = 1'b0;
        set_in(NOP_INSTR, NOP_INSTR, 1'b0);
        tick();

        for (int i = 0; i < 14; i++) begin
            set_in(tv[i].id_ex, tv[i].if_id, tv[i].br);
            @(negedge clk);
            chk(tv[i].name, 32'(o1), 32'(tv[i].exp));
            tick();
        end

        // single-cycle load-use stall
        do_reset();
        set_in(LW5, ADD5, 1'b0);
        @(negedge clk);
        chk("lat1_stall_out", 32'(o1), 32'(4'b0010));
        chk("lat1_cnt_before", sc1, 0);
        tick();
        id_ex = NOP_INSTR;
        @(negedge clk);
        chk("lat1_resume_out", 32'(o1), 32'(4'b1100));
        chk("lat1_cnt_after", sc1, 1);
        tick();

        // three-cycle stall
        do_reset();
        set_in(LW5, ADD5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("lat3_cycle%0d", k), 32'(o3), k < 3 ? 32'(4'b0010) : 32'(4'b1100));
            tick();
            id_ex = NOP_INSTR;
        end
        @(negedge clk);
        chk("lat3_stall_cnt", sc3, 3);

        // flush with a simultaneous hazard, then flush during a STALL
        do_reset();
        set_in(LW5, ADD5, 1'b1);
        @(negedge clk);
        chk("flush_hazard_u1", 32'(o1), 32'(4'b1111));
        chk("flush_hazard_u3", 32'(o3), 32'(4'b1111));
        tick();
        set_in(NOP_INSTR, ADD5, 1'b0);
        @(negedge clk);
        chk("flush_cnt_inc", fc1, 1);
        chk("flush_no_stall_cnt", sc1, 0);
        set_in(LW5, ADD5, 1'b0);
        tick();
        set_in(NOP_INSTR, ADD5, 1'b1);
        @(negedge clk);
        chk("flush_in_stall_out", 32'(o3), 32'(4'b1111));
        tick();
        br = 1'b0;
        @(negedge clk);
        chk("flush_in_stall_resume", 32'(o3), 32'(4'b1100));
        chk("flush_in_stall_fcnt", fc3, 2);
        chk("flush_in_stall_scnt", sc3, 1);

        // asynchronous reset in the middle of a 4-cycle stall
        tick();
        do_reset();
        set_in(LW5, ADD5, 1'b0);
        tick();
        id_ex = NOP_INSTR;
        tick();
        #2;
        chk("mid_stall_before_rst", 32'(o4), 32'(4'b0010));
        rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(o4), 32'(4'b1100));
        chk("async_rst_scnt", 32'(sc4), 0);
        chk("async_rst_fcnt", 32'(fc4), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        set_in(LW5, ADD5, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("lat4_cycle%0d", k), 32'(pc4), k < 4 ? 0 : 1);
            tick();
            id_ex = NOP_INSTR;
        end
        @(negedge clk);
        chk("lat4_stall_cnt", 32'(sc4), 4);

        // saturation of 4-bit counters
        tick();
        do_reset();
        for (int h = 0; h < 5; h++) begin
            set_in(LW5, ADD5, 1'b0);
            tick();
            id_ex = NOP_INSTR;
            repeat (4) tick();
            if (h == 2) begin
                @(negedge clk);
                chk("sat_scnt_12", 32'(sc4), 12);
                tick();
            end
        end
        @(negedge clk);
        chk("sat_scnt_15", 32'(sc4), 15);
        chk("sat_wide_scnt", sc1, 5);
        br = 1'b1;
        repeat (16) tick();
        br = 1'b0;
        @(negedge clk);
        chk("sat_fcnt_15", 32'(fc4), 15);
        chk("wide_fcnt_16", fc1, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
